uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_in  input  8  byte to transmit.
REQ-006 SHALL have port data_in_valid  input  1  data_in holds a byte offered for transfer.
REQ-007 SHALL have port data_in_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port serial_out  output  1  UART line; idle high.
REQ-009 SHALL have port busy  output  1  a frame is on the line or a byte is held.

Function
REQ-010 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, truncated integer (default 868); values < 2 are unsupported.
REQ-011 SHALL size the symbol counter at clog2(SYMBOL_EDGE_TIME) bits and count 0..SYMBOL_EDGE_TIME-1, wrapping to 0.
REQ-012 SHALL transfer a byte only in a cycle where data_in_valid and data_in_ready are both 1; data_in is ignored otherwise.
REQ-013 SHALL contain one 8-bit holding register plus a frame shift register (double buffering).
REQ-014 SHALL drive data_in_ready = 1 exactly when the holding register is empty and rst is 0, as a registered output.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 SHALL transmit 8N1 frames: start bit 0, data bits LSB first, one stop bit 1; each bit held for exactly SYMBOL_EDGE_TIME cycles; frame = 10*SYMBOL_EDGE_TIME cycles.
REQ-017 IDLE: serial_out = 1; on accepted byte (or holding register full), load shifter, go START.
REQ-018 From IDLE, with a transfer in cycle N, serial_out SHALL be 0 from cycle N+1 (byte bypasses the holding register).
REQ-019 START -> DATA after SYMBOL_EDGE_TIME cycles; DATA -> STOP after 8 symbols (3-bit bit index, 0..7); STOP -> IDLE after SYMBOL_EDGE_TIME cycles if holding empty.
REQ-020 At the last STOP cycle with holding register full, SHALL move held byte into shifter and enter START with no idle cycle between frames; holding register becomes empty and data_in_ready rises the next cycle.
REQ-021 At the last STOP cycle with holding empty and a transfer in the same cycle, SHALL route the new byte directly to the shifter and start back-to-back as in REQ-020.
REQ-022 A transfer during START/DATA/STOP (not the last STOP cycle) SHALL fill the holding register; data_in_ready = 0 from the next cycle.
REQ-023 SHALL drive busy = 1 whenever state != IDLE or holding register full; busy is registered.
REQ-024 serial_out SHALL come directly from a flop (glitch-free).
REQ-025 data_in_valid deasserted without transfer SHALL have no effect; no requirement that valid stay high.

Reset
REQ-026 While rst = 1 on a clock edge: state IDLE, serial_out = 1, data_in_ready = 0, busy = 0, counters 0, holding register empty.
REQ-027 rst mid-frame SHALL abort the frame; serial_out = 1 from the next cycle; held byte discarded; no partial retransmission.
REQ-028 data_in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 A transfer cannot occur in a cycle where rst = 1.

Verification
REQ-030 Single byte 0xA5 after reset (defaults) -> serial_out: 0 for 868 cycles, then 1,0,1,0,0,1,0,1 each 868 cycles, then 1; total 8680 cycles; busy falls after stop bit.
REQ-031 Bytes 0x00 then 0xFF offered back-to-back with valid held -> second accepted during first frame, data_in_ready low until first stop ends; 0xFF start bit begins the cycle after the 0x00 stop bit with no gap.
REQ-032 Third byte 0x3C offered while shifter and holding full -> data_in_ready = 0, byte not accepted until holding drains; 0x3C sent only after valid held through acceptance.
REQ-033 rst asserted during DATA bit 4 of 0x55 with holding full -> serial_out = 1 next cycle, busy = 0, data_in_ready = 1 one cycle after rst released; no further frame emitted.
REQ-034 CLOCK_FREQ = 1_000, BAUD_RATE = 250 (SYMBOL_EDGE_TIME = 4), byte 0x81 -> each bit lasts 4 cycles, frame 40 cycles, bit order 0,1,0,0,0,0,0,0,1,1.
REQ-035 Sample serial_out at every symbol midpoint with a reference receiver for 256 random bytes with random valid gaps -> all bytes recovered in order, no lost or duplicate bytes.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmit path with a one-byte holding register
// in front of the frame shifter. A byte can be accepted while another frame
// is on the line, so two bytes can be queued without gaps between frames.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out,
   output logic       busy
);

   // Clock cycles per bit on the line (truncated); must be at least 2.
   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;       // cycle position inside current bit
   logic [2:0]       bit_q, bit_d;       // data bit index 0..7
   logic [7:0]       shift_q, shift_d;   // frame shifter, LSB is on the line
   logic [7:0]       hold_q, hold_d;     // second-level buffer
   logic             hold_full_q, hold_full_d;
   logic             ready_q, ready_d;
   logic             serial_q, serial_d;
   logic             busy_q, busy_d;

   logic             xfer;      // handshake completes this cycle
   logic             sym_end;   // last cycle of the current bit
   logic             take;      // accepted byte goes straight to the shifter

   assign xfer    = data_in_valid & ready_q & ~rst;
   assign sym_end = (cnt_q == CNT_LAST);

   // All outputs come straight from flops.
   assign data_in_ready = ready_q;
   assign serial_out    = serial_q;
   assign busy          = busy_q;

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      serial_d    = serial_q;
      take        = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            bit_d    = '0;
            serial_d = 1'b1;
            if (hold_full_q) begin
               // Held byte left over: launch it.
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               serial_d    = 1'b0;
               state_d     = START;
            end else if (xfer) begin
               // Fresh byte bypasses the holding register so the start
               // bit appears on the very next cycle.
               shift_d  = data_in;
               take     = 1'b1;
               serial_d = 1'b0;
               state_d  = START;
            end
         end

         START: begin
            cnt_d = sym_end ? '0 : cnt_q + CNT_W'(1);
            if (sym_end) begin
               bit_d    = '0;
               serial_d = shift_q[0];
               state_d  = DATA;
            end
         end

         DATA: begin
            cnt_d = sym_end ? '0 : cnt_q + CNT_W'(1);
            if (sym_end) begin
               if (bit_q == 3'd7) begin
                  serial_d = 1'b1;
                  state_d  = STOP;
               end else begin
                  bit_d    = bit_q + 3'd1;
                  shift_d  = {1'b0, shift_q[7:1]};
                  serial_d = shift_q[1];
               end
            end
         end

         STOP: begin
            cnt_d = sym_end ? '0 : cnt_q + CNT_W'(1);
            if (sym_end) begin
               if (hold_full_q) begin
                  // Back-to-back frame from the holding register.
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  serial_d    = 1'b0;
                  state_d     = START;
               end else if (xfer) begin
                  // Byte arriving exactly at the frame boundary goes
                  // directly to the shifter, again with no idle gap.
                  shift_d  = data_in;
                  take     = 1'b1;
                  serial_d = 1'b0;
                  state_d  = START;
               end else begin
                  serial_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end

         default: begin
            state_d  = IDLE;
            serial_d = 1'b1;
         end
      endcase

      // Any accepted byte not taken by the shifter is parked.
      if (xfer && !take) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      ready_d = ~hold_full_d;
      busy_d  = (state_d != IDLE) | hold_full_d;
   end

   // State and output registers; reset aborts any frame and drops the held byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         ready_q     <= 1'b0;
         serial_q    <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         ready_q     <= ready_d;
         serial_q    <= serial_d;
         busy_q      <= busy_d;
      end
   end

endmodule
